// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the combinational gate sweep checker: FSM state encoding
// and reference truth tables for the 2-input library cells.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bit k is the expected gate output when the input vector equals k.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_sweep_checker.sv
// Walks every input combination of an N_IN-input gate, samples Y_IN after SETTLE cycles
// per vector and counts mismatches against EXPECT. Optional logging: GATE_SWEEP_LOG_EN.
//
// state  | meaning
// IDLE   | waiting for START, results of the last sweep held
// WAIT   | driving IN_VEC, settling, sampling on the last cycle of the window
// FINISH | one-cycle DONE pulse, results final, IN_VEC returned to 0
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [2**N_IN-1:0]   EXPECT = TT_AND2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    output logic [N_IN-1:0] IN_VEC,
    input  logic            Y_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic [N_IN-1:0] FIRST_ERR
);

    localparam int              WCW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(SETTLE - 1);
    localparam logic [WCW-1:0]  WAIT_ONE  = WCW'(1);
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

    state_t          state, state_nxt;
    logic [WCW-1:0]  wait_cnt, wait_cnt_nxt;
    logic [N_IN-1:0] vec_nxt;
    logic [N_IN-1:0] first_nxt;
    logic [N_IN:0]   err_nxt;
    logic            pass_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            sample;
    logic            mismatch;

    assign sample   = (state == WAIT) && (wait_cnt >= WAIT_LAST);
    assign mismatch = (Y_IN != EXPECT[IN_VEC]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BUSY/DONE/PASS are registered from the next state so every output is a flop
    // and PASS/ERR_CNT are already final during the DONE cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        vec_nxt      = IN_VEC;
        err_nxt      = ERR_CNT;
        first_nxt    = FIRST_ERR;
        pass_nxt     = PASS;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt    = WAIT;
                    vec_nxt      = '0;
                    wait_cnt_nxt = '0;
                    err_nxt      = '0;
                    first_nxt    = '0;
                    pass_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end

            WAIT: begin
                busy_nxt = 1'b1;
                if (!sample) begin
                    wait_cnt_nxt = wait_cnt + WAIT_ONE;
                end else begin
                    if (mismatch) begin
                        err_nxt = ERR_CNT + ERR_ONE;
                        if (ERR_CNT == '0) begin
                            first_nxt = IN_VEC;
                        end
                    end
                    if (IN_VEC == '1) begin
                        state_nxt = FINISH;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0);
                    end else begin
                        vec_nxt      = IN_VEC + VEC_ONE;
                        wait_cnt_nxt = '0;
                    end
                end
            end

            FINISH: begin
                vec_nxt   = '0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt  <= '0;
            IN_VEC    <= '0;
            ERR_CNT   <= '0;
            FIRST_ERR <= '0;
            PASS      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            IN_VEC    <= vec_nxt;
            ERR_CNT   <= err_nxt;
            FIRST_ERR <= first_nxt;
            PASS      <= pass_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
        end
    end

`ifdef GATE_SWEEP_LOG_EN
    always @(posedge CLK) begin
        if (!RST) begin
            if (sample) begin
                $display("Time: %0t | IN: %b, Y: %b, EXP: %b%s", $time, IN_VEC, Y_IN,
                         EXPECT[IN_VEC], mismatch ? " MISMATCH" : "");
            end
            if (state == FINISH) begin
                $display("Time: %0t | ERR_CNT: %0d, PASS: %b", $time, ERR_CNT, PASS);
            end
        end
    end
`else
    // Logging disabled: no simulation-only code in this build.
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: per-cycle vector table on a 2-input AND/OR
// model plus hand-written reset-abort and long-settle sequences.
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       START3 = 1'b0;
    logic       fault = 1'b0;

    logic [1:0] in_vec;
    logic       y;
    logic       busy, done, pass;
    logic [2:0] err;
    logic [1:0] first;

    logic [2:0] in_vec3;
    logic       y3;
    logic       busy3, done3, pass3;
    logic [3:0] err3;
    logic [2:0] first3;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // Gate under test: AND2, or OR2 when the fault is injected.
    assign y  = fault ? (in_vec[0] | in_vec[1]) : (in_vec[0] & in_vec[1]);
    assign y3 = 1'b1;

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXPECT(TT_AND2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VEC(in_vec), .Y_IN(y),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err), .FIRST_ERR(first)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(3), .EXPECT(8'b1111_1110)) dut3 (
        .CLK(CLK), .RST(RST), .START(START3), .IN_VEC(in_vec3), .Y_IN(y3),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .FIRST_ERR(first3)
    );

    typedef struct {
        logic       start;
        logic       fault;
        logic       chk_vec;
        logic [1:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [2:0] err;
        logic [1:0] first;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic s, input logic f, input logic cv, input logic [1:0] v,
                                input logic b, input logic d, input logic p,
                                input logic [2:0] e, input logic [1:0] fe);
        row_t r;
        r.start = s; r.fault = f; r.chk_vec = cv; r.vec = v;
        r.busy = b; r.done = d; r.pass = p; r.err = e; r.first = fe;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        int waited;

        // Good AND2 sweep
        tbl.push_back(mk(1, 0, 1, 2'd0, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd2, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd3, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 0, 1, 3'd0, 2'd0));
        // Faulty gate (OR behaviour): vectors 1 and 2 mismatch
        tbl.push_back(mk(1, 1, 1, 2'd0, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 1, 1, 2'd1, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 1, 1, 2'd2, 1, 0, 0, 3'd1, 2'd1));
        tbl.push_back(mk(0, 1, 1, 2'd3, 1, 0, 0, 3'd2, 2'd1));
        tbl.push_back(mk(0, 1, 0, 2'd0, 0, 1, 0, 3'd2, 2'd1));
        tbl.push_back(mk(0, 1, 1, 2'd0, 0, 0, 0, 3'd2, 2'd1));
        // Second START mid-sweep is ignored
        tbl.push_back(mk(1, 0, 1, 2'd0, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(1, 0, 1, 2'd2, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd3, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 0, 1, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 0, 1, 3'd0, 2'd0));
        // START held high: faulty sweep, then fixed gate restarts on first IDLE cycle
        tbl.push_back(mk(1, 1, 1, 2'd0, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(1, 1, 1, 2'd1, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(1, 1, 1, 2'd2, 1, 0, 0, 3'd1, 2'd1));
        tbl.push_back(mk(1, 1, 1, 2'd3, 1, 0, 0, 3'd2, 2'd1));
        tbl.push_back(mk(1, 1, 0, 2'd0, 0, 1, 0, 3'd2, 2'd1));
        tbl.push_back(mk(1, 0, 1, 2'd0, 0, 0, 0, 3'd2, 2'd1));
        tbl.push_back(mk(1, 0, 1, 2'd0, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd2, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd3, 1, 0, 0, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 2'd0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 0, 0, 1, 3'd0, 2'd0));

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst in_vec", in_vec, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst err", err, 0);
        check("rst first", first, 0);
        check("rst busy3", busy3, 0);
        @(negedge CLK) RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            START = tbl[i].start;
            fault = tbl[i].fault;
            @(posedge CLK);
            #1;
            if (tbl[i].chk_vec) check($sformatf("row%0d in_vec", i), in_vec, tbl[i].vec);
            check($sformatf("row%0d busy", i), busy, tbl[i].busy);
            check($sformatf("row%0d done", i), done, tbl[i].done);
            check($sformatf("row%0d pass", i), pass, tbl[i].pass);
            check($sformatf("row%0d err", i), err, tbl[i].err);
            check($sformatf("row%0d first", i), first, tbl[i].first);
        end
        @(negedge CLK);
        START = 1'b0;
        fault = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset mid-sweep with a faulty gate so the error state is non-zero first
        fault = 1'b1;
        START = 1'b1;
        @(negedge CLK) START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("abort pre err", err, 1);
        check("abort pre busy", busy, 1);
        RST = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort in_vec", in_vec, 0);
        check("abort err", err, 0);
        check("abort first", first, 0);
        check("abort pass", pass, 0);
        check("abort done", done, 0);
        done_seen = 0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (done) done_seen++;
        end
        @(negedge CLK);
        RST = 1'b0;
        fault = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (done) done_seen++;
        end
        check("abort no done", done_seen, 0);
        check("abort idle busy", busy, 0);

        // Fresh sweep after the abort
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        waited = 0;
        while (!done && waited < 20) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        check("resweep done", done, 1);
        check("resweep pass", pass, 1);
        check("resweep err", err, 0);
        check("resweep first", first, 0);

        // SETTLE=3, N_IN=3, stuck-at-1 output against OR3 table: only vector 0 fails
        @(negedge CLK) START3 = 1'b1;
        @(posedge CLK);
        #1;
        START3 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("settle k%0d in_vec", k), in_vec3, k / 3);
            check($sformatf("settle k%0d busy", k), busy3, 1);
            check($sformatf("settle k%0d done", k), done3, 0);
            @(posedge CLK);
            #1;
        end
        check("settle done", done3, 1);
        check("settle busy", busy3, 0);
        check("settle err", err3, 1);
        check("settle first", first3, 0);
        check("settle pass", pass3, 0);
        @(posedge CLK);
        #1;
        check("settle done pulse", done3, 0);
        check("settle err hold", err3, 1);
        check("settle in_vec idle", in_vec3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
